// File: rtl/falu_arbiter.sv
// Round-robin arbiter that shares one falu between NREQ requesters.
// One operation is in flight at a time: grant -> start pulse -> wait for
// completion (or watchdog) -> hold response until the granted requester takes it.
module falu_arbiter #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_op_a,
    input  logic [32*NREQ-1:0]   req_op_b,
    input  logic [2*NREQ-1:0]    req_op_code,
    input  logic [NREQ-1:0]      req_mode_fp,
    input  logic [NREQ-1:0]      req_round_mode,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [31:0]          rsp_result,
    output logic [4:0]           rsp_flags,
    output logic                 rsp_timeout,
    output logic                 alu_start,
    output logic [31:0]          alu_op_a,
    output logic [31:0]          alu_op_b,
    output logic [1:0]           alu_op_code,
    output logic                 alu_mode_fp,
    output logic                 alu_round_mode,
    input  logic [31:0]          alu_result,
    input  logic [4:0]           alu_flags,
    input  logic                 alu_valid_out
);

    localparam int PW = (NREQ > 2) ? 2 : 1;
    localparam int WW = $clog2(TIMEOUT);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]     grant_q, grant_d;
    logic [WW-1:0]     wd_cnt_q, wd_cnt_d;
    logic [NREQ-1:0]   req_ready_q, req_ready_d;
    logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic              alu_start_q, alu_start_d;
    logic [31:0]       alu_op_a_q, alu_op_a_d;
    logic [31:0]       alu_op_b_q, alu_op_b_d;
    logic [1:0]        alu_op_code_q, alu_op_code_d;
    logic              alu_mode_fp_q, alu_mode_fp_d;
    logic              alu_round_mode_q, alu_round_mode_d;
    logic [31:0]       rsp_result_q, rsp_result_d;
    logic [4:0]        rsp_flags_q, rsp_flags_d;
    logic              rsp_timeout_q, rsp_timeout_d;

    // Per-requester views of the packed operand buses.
    logic [31:0] op_a_arr [NREQ];
    logic [31:0] op_b_arr [NREQ];
    logic [1:0]  op_code_arr [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign op_a_arr[gi]    = req_op_a[gi*32 +: 32];
        assign op_b_arr[gi]    = req_op_b[gi*32 +: 32];
        assign op_code_arr[gi] = req_op_code[gi*2 +: 2];
    end

    logic          win_found;
    logic [PW-1:0] win_idx;
    int            cand;

    // Round-robin search starting at rr_ptr; iterating downward lets the
    // candidate closest to the pointer overwrite the others.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (req_valid[PW'(cand)]) begin
                win_found = 1'b1;
                win_idx   = PW'(cand);
            end
        end
    end

    // Next-state and registered-output computation for the arbitration FSM.
    always_comb begin
        state_d          = state_q;
        rr_ptr_d         = rr_ptr_q;
        grant_d          = grant_q;
        wd_cnt_d         = wd_cnt_q;
        req_ready_d      = '0;
        rsp_valid_d      = rsp_valid_q;
        alu_start_d      = 1'b0;
        alu_op_a_d       = alu_op_a_q;
        alu_op_b_d       = alu_op_b_q;
        alu_op_code_d    = alu_op_code_q;
        alu_mode_fp_d    = alu_mode_fp_q;
        alu_round_mode_d = alu_round_mode_q;
        rsp_result_d     = rsp_result_q;
        rsp_flags_d      = rsp_flags_q;
        rsp_timeout_d    = rsp_timeout_q;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    req_ready_d      = NREQ'(1) << win_idx;
                    grant_d          = win_idx;
                    alu_op_a_d       = op_a_arr[win_idx];
                    alu_op_b_d       = op_b_arr[win_idx];
                    alu_op_code_d    = op_code_arr[win_idx];
                    alu_mode_fp_d    = req_mode_fp[win_idx];
                    alu_round_mode_d = req_round_mode[win_idx];
                    state_d          = S_ISSUE;
                end
            end
            S_ISSUE: begin
                alu_start_d = 1'b1;
                wd_cnt_d    = '0;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                wd_cnt_d = wd_cnt_q + WW'(1);
                // Completion takes priority over a coincident watchdog expiry.
                if (alu_valid_out) begin
                    rsp_result_d  = alu_result;
                    rsp_flags_d   = alu_flags;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = NREQ'(1) << grant_q;
                    state_d       = S_RESP;
                end else if (wd_cnt_q == WD_LAST) begin
                    rsp_result_d  = '0;
                    rsp_flags_d   = '0;
                    rsp_timeout_d = 1'b1;
                    rsp_valid_d   = NREQ'(1) << grant_q;
                    state_d       = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready[grant_q]) begin
                    rsp_valid_d = '0;
                    rr_ptr_d    = (grant_q == PW'(NREQ - 1)) ? '0 : grant_q + PW'(1);
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset abandons any in-flight operation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= S_IDLE;
            rr_ptr_q         <= '0;
            grant_q          <= '0;
            wd_cnt_q         <= '0;
            req_ready_q      <= '0;
            rsp_valid_q      <= '0;
            alu_start_q      <= 1'b0;
            alu_op_a_q       <= '0;
            alu_op_b_q       <= '0;
            alu_op_code_q    <= '0;
            alu_mode_fp_q    <= 1'b0;
            alu_round_mode_q <= 1'b0;
            rsp_result_q     <= '0;
            rsp_flags_q      <= '0;
            rsp_timeout_q    <= 1'b0;
        end else begin
            state_q          <= state_d;
            rr_ptr_q         <= rr_ptr_d;
            grant_q          <= grant_d;
            wd_cnt_q         <= wd_cnt_d;
            req_ready_q      <= req_ready_d;
            rsp_valid_q      <= rsp_valid_d;
            alu_start_q      <= alu_start_d;
            alu_op_a_q       <= alu_op_a_d;
            alu_op_b_q       <= alu_op_b_d;
            alu_op_code_q    <= alu_op_code_d;
            alu_mode_fp_q    <= alu_mode_fp_d;
            alu_round_mode_q <= alu_round_mode_d;
            rsp_result_q     <= rsp_result_d;
            rsp_flags_q      <= rsp_flags_d;
            rsp_timeout_q    <= rsp_timeout_d;
        end
    end

    assign req_ready      = req_ready_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_result     = rsp_result_q;
    assign rsp_flags      = rsp_flags_q;
    assign rsp_timeout    = rsp_timeout_q;
    assign alu_start      = alu_start_q;
    assign alu_op_a       = alu_op_a_q;
    assign alu_op_b       = alu_op_b_q;
    assign alu_op_code    = alu_op_code_q;
    assign alu_mode_fp    = alu_mode_fp_q;
    assign alu_round_mode = alu_round_mode_q;

endmodule

// File: tb/tb_falu_arbiter.sv
// Directed bench for falu_arbiter with a small falu stand-in:
// result = a ^ b, flags = {op_code, mode_fp, round_mode, 0}, valid 3 cycles after start.
module tb_falu_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_op_a;
    logic [63:0] req_op_b;
    logic [3:0]  req_op_code;
    logic [1:0]  req_mode_fp;
    logic [1:0]  req_round_mode;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_result;
    logic [4:0]  rsp_flags;
    logic        rsp_timeout;
    logic        alu_start;
    logic [31:0] alu_op_a;
    logic [31:0] alu_op_b;
    logic [1:0]  alu_op_code;
    logic        alu_mode_fp;
    logic        alu_round_mode;
    logic [31:0] alu_result;
    logic [4:0]  alu_flags;
    logic        alu_valid_out;

    logic        model_en;
    logic        stale;
    logic [2:0]  pipe_q = '0;
    logic [31:0] m_res = '0;
    logic [4:0]  m_flags = '0;

    int checks = 0;
    int failures = 0;

    falu_arbiter #(.NREQ(2), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op_a(req_op_a), .req_op_b(req_op_b), .req_op_code(req_op_code),
        .req_mode_fp(req_mode_fp), .req_round_mode(req_round_mode),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_timeout(rsp_timeout),
        .alu_start(alu_start), .alu_op_a(alu_op_a), .alu_op_b(alu_op_b),
        .alu_op_code(alu_op_code), .alu_mode_fp(alu_mode_fp), .alu_round_mode(alu_round_mode),
        .alu_result(alu_result), .alu_flags(alu_flags), .alu_valid_out(alu_valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // falu stand-in
    always @(posedge clk) begin
        pipe_q <= {pipe_q[1:0], alu_start & model_en};
        if (alu_start) begin
            m_res   <= alu_op_a ^ alu_op_b;
            m_flags <= {alu_op_code, alu_mode_fp, alu_round_mode, 1'b0};
        end
    end
    assign alu_result    = m_res;
    assign alu_flags     = m_flags;
    assign alu_valid_out = pipe_q[2] | stale;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] oh(input int g);
        logic [1:0] one;
        one = 2'b01;
        return one << g;
    endfunction

    task automatic wait_grant(input int g);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (req_ready == 2'b00 && n < 20);
        check("grant", 32'(req_ready), 32'(oh(g)));
    endtask

    // From the grant cycle: wait for the response, check it, then accept it.
    task automatic finish(input int g, input int lat, input int st,
                          input logic [31:0] er, input logic [4:0] ef, input logic et);
        int n;
        int first;
        int cnt;
        n = 0; first = 0; cnt = 0;
        while (rsp_valid == 2'b00 && n < 40) begin
            tick();
            n++;
            if (n == 1) check("ready_pulse", 32'(req_ready), 32'd0);
            if (alu_start) begin
                cnt++;
                if (first == 0) first = n;
            end
        end
        check("rsp_latency", 32'(n), 32'(lat));
        check("start_tick", 32'(first), 32'(st));
        check("start_count", 32'(cnt), (st != 0) ? 32'd1 : 32'd0);
        check("rsp_valid", 32'(rsp_valid), 32'(oh(g)));
        check("rsp_result", rsp_result, er);
        check("rsp_flags", 32'(rsp_flags), 32'(ef));
        check("rsp_timeout", 32'(rsp_timeout), 32'(et));
        rsp_ready = oh(g);
        tick();
        check("rsp_cleared", 32'(rsp_valid), 32'd0);
        rsp_ready = 2'b00;
    endtask

    initial begin
        rst = 1'b0; req_valid = '0; req_op_a = '0; req_op_b = '0; req_op_code = '0;
        req_mode_fp = '0; req_round_mode = '0; rsp_ready = '0; model_en = 1'b1; stale = 1'b0;
        tick(); tick();
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_start", 32'(alu_start), 32'd0);
        check("rst_outs", {rsp_result ^ alu_op_a ^ alu_op_b, 32'(rsp_flags), 32'(rsp_timeout)} == '0 ? 32'd0 : 32'd1, 32'd0);
        rst = 1'b1;

        // 1: single request
        req_op_a[31:0] = 32'h3F800000; req_op_b[31:0] = 32'h40000000; req_op_code[1:0] = 2'd2;
        req_valid = 2'b01;
        wait_grant(0);
        req_valid = 2'b00;
        check("lat_op_a", alu_op_a, 32'h3F800000);
        check("lat_op_b", alu_op_b, 32'h40000000);
        check("lat_op_code", 32'(alu_op_code), 32'd2);
        finish(0, 5, 1, 32'h7F800000, 5'b10000, 1'b0);

        // 2: contention from a fresh pointer
        rst = 1'b0; tick(); rst = 1'b1;
        req_op_a = {32'hFFFF0000, 32'h00000001};
        req_op_b = {32'h0F0F0F0F, 32'h00000003};
        req_op_code = {2'd3, 2'd1};
        req_mode_fp = 2'b01; req_round_mode = 2'b10;
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_grant(k % 2);
            if (k % 2 == 0) finish(0, 5, 1, 32'h00000002, 5'b01100, 1'b0);
            else            finish(1, 5, 1, 32'hF0F00F0F, 5'b11010, 1'b0);
        end
        req_valid = 2'b00;

        // 4: response backpressure on requester 1 while requester 0 waits
        req_valid = 2'b10;
        wait_grant(1);
        req_valid = 2'b01;
        begin
            int n;
            n = 0;
            while (rsp_valid == 2'b00 && n < 40) begin tick(); n++; end
        end
        check("bp_rsp_valid", 32'(rsp_valid), 32'h2);
        rsp_ready = 2'b01;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("bp_hold_valid", 32'(rsp_valid), 32'h2);
            check("bp_hold_result", rsp_result, 32'hF0F00F0F);
            check("bp_no_grant", 32'(req_ready), 32'd0);
        end
        rsp_ready = 2'b10;
        tick();
        rsp_ready = 2'b00;
        check("bp_cleared", 32'(rsp_valid), 32'd0);
        check("bp_idle_no_grant", 32'(req_ready), 32'd0);
        tick();
        check("bp_grant0", 32'(req_ready), 32'h1);
        req_valid = 2'b00;
        finish(0, 5, 1, 32'h00000002, 5'b01100, 1'b0);

        // 3: watchdog timeout
        model_en = 1'b0;
        req_valid = 2'b01;
        wait_grant(0);
        req_valid = 2'b00;
        finish(0, 9, 1, 32'h0, 5'b0, 1'b1);
        model_en = 1'b1;

        // 5: asynchronous reset in the middle of WAIT
        req_valid = 2'b01;
        wait_grant(0);
        req_valid = 2'b00;
        tick();
        check("r5_start", 32'(alu_start), 32'd1);
        tick();
        rst = 1'b0;
        #1;
        check("r5_ready", 32'(req_ready), 32'd0);
        check("r5_rsp_valid", 32'(rsp_valid), 32'd0);
        check("r5_start_low", 32'(alu_start), 32'd0);
        check("r5_op_a", alu_op_a, 32'd0);
        check("r5_op_b", alu_op_b, 32'd0);
        check("r5_ctl", {27'd0, alu_op_code, alu_mode_fp, alu_round_mode, rsp_timeout}, 32'd0);
        check("r5_rsp", rsp_result | 32'(rsp_flags), 32'd0);
        req_valid = 2'b10;
        tick(); tick();
        rst = 1'b1;
        wait_grant(1);
        req_valid = 2'b00;
        finish(1, 5, 1, 32'hF0F00F0F, 5'b11010, 1'b0);

        // 6: level-held valid_out during IDLE and ISSUE is ignored
        stale = 1'b1;
        tick(); tick();
        check("s6_idle_no_rsp", 32'(rsp_valid), 32'd0);
        req_valid = 2'b01;
        wait_grant(0);
        req_valid = 2'b00;
        tick();
        check("s6_start", 32'(alu_start), 32'd1);
        check("s6_no_early_rsp", 32'(rsp_valid), 32'd0);
        stale = 1'b0;
        finish(0, 4, 0, 32'h00000002, 5'b01100, 1'b0);
        stale = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("s6_single_rsp", 32'(rsp_valid), 32'd0);
            check("s6_no_regrant", 32'(req_ready), 32'd0);
        end
        stale = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
